// File: rtl/sd_spi_host_pkg.sv
// sd_spi_host_pkg: shared state type, CRC polynomial and byte-wide CRC16 step for the SPI host
package sd_spi_host_pkg;
    typedef enum logic [1:0] {SPI_IDLE, SPI_LOW, SPI_HIGH, SPI_DONE} spi_state_t;
    localparam logic [15:0] SPI_CRC_POLY = 16'h1021;
    // one CRC16-CCITT update over a byte, MSB first
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] din);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ din[i]) ? SPI_CRC_POLY : 16'h0000);
        return c;
    endfunction
endpackage

// File: rtl/sd_spi_host_if.sv
// sd_spi_host_if: Z80 I/O bus strobes, address and write data seen by the SPI host
interface sd_spi_host_if;
    logic       ioreq;
    logic       rd;
    logic       wr;
    logic [7:0] a_reg;
    logic [7:0] d_reg;
    modport master (output ioreq, rd, wr, a_reg, d_reg);
    modport slave  (input ioreq, rd, wr, a_reg, d_reg);
endinterface

// File: rtl/spi_crc16.sv
// spi_crc16: byte-parallel CRC16-CCITT accumulator (init 0), present only when SPI_CRC16_EN is defined
`ifdef SPI_CRC16_EN
module spi_crc16
    import sd_spi_host_pkg::*;
(
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  din_i,
    output logic [15:0] crc_o
);
    logic [15:0] crc_q;
    assign crc_o = crc_q;
    // clear has priority over an update arriving in the same cycle
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else if (clr_i) crc_q <= '0;
        else if (en_i) crc_q <= crc16_byte(crc_q, din_i);
    end
endmodule
`endif

// File: rtl/sd_spi_host.sv
// sd_spi_host: DivMMC-compatible SPI host with N chip selects and run-time divider; SPI_CRC16_EN adds a CRC16 read port
module sd_spi_host
    import sd_spi_host_pkg::*;
#(
    parameter int          NUM_CS    = 2,
    parameter int          DIV_W     = 4,
    parameter int          DIV_RESET = 1,
    parameter logic [7:0]  DATA_PORT = 8'hEB,
    parameter logic [7:0]  CTRL_PORT = 8'hE7,
    parameter logic [7:0]  DIV_PORT  = 8'hEF
`ifdef SPI_CRC16_EN
  , parameter logic [7:0]  CRC_PORT  = 8'hF3
`endif
)(
    input  logic              clk28,
    input  logic              rst_n,
    input  logic              en_i,
    sd_spi_host_if.slave      bus,
    output logic [7:0]        d_out_o,
    output logic              d_out_active_o,
    input  logic              sd_miso_i,
    output logic              sd_mosi_o,
    output logic              sd_sck_o,
    output logic [NUM_CS-1:0] sd_cs_n_o,
    output logic              busy_o,
    output logic              spi_wait_o
);
    spi_state_t        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, div_lat_q, div_lat_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d, rx_q, rx_d, d_out_q, d_out_d;
    logic              mosi_q, mosi_d, sck_q, sck_d, d_act_q, d_act_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic              acc, hit_crc;
    logic [3:0]        hit, hit_q, fire;
    logic [7:0]        crc_byte;
    // hit bits: 0 data, 1 ctrl, 2 div, 3 crc; fire is the first cycle of each access
    assign acc  = en_i & bus.ioreq & (bus.rd | bus.wr);
    assign hit  = {hit_crc, acc & (bus.a_reg == DIV_PORT), acc & (bus.a_reg == CTRL_PORT), acc & (bus.a_reg == DATA_PORT)};
    assign fire = hit & ~hit_q;
`ifdef SPI_CRC16_EN
    logic [15:0] crc;
    logic        ptr_q, crc_clr;
    assign hit_crc  = acc & (bus.a_reg == CRC_PORT);
    assign crc_clr  = fire[1] & bus.wr & bus.d_reg[7];
    assign crc_byte = ptr_q ? crc[7:0] : crc[15:8];
    spi_crc16 u_crc (
        .clk28 (clk28),
        .rst_n (rst_n),
        .clr_i (crc_clr),
        .en_i  (state_q == SPI_DONE),
        .din_i (sh_q),
        .crc_o (crc)
    );
    // CRC read pointer: high byte first, toggles per read, clear rewinds it
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else if (crc_clr) ptr_q <= 1'b0;
        else if (fire[3] & bus.rd) ptr_q <= ~ptr_q;
    end
`else
    assign hit_crc  = 1'b0;
    assign crc_byte = 8'h00;
`endif
    // port actions and the bit-serial FSM; sh is both the outgoing and incoming shift register
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rx_d      = rx_q;
        mosi_d    = mosi_q;
        sck_d     = sck_q;
        div_lat_d = div_lat_q;
        cs_d      = (fire[1] & bus.wr) ? bus.d_reg[NUM_CS-1:0] : cs_q;
        div_d     = (fire[2] & bus.wr) ? bus.d_reg[DIV_W-1:0] : div_q;
        d_act_d   = bus.rd & (hit[0] | hit[2] | hit[3]);
        d_out_d   = d_out_q;
        if (fire[0] & bus.rd & ~bus.wr) d_out_d = rx_q;
        if (fire[2] & bus.rd & ~bus.wr) d_out_d = 8'(div_q);
        if (fire[3] & bus.rd) d_out_d = crc_byte;
        case (state_q)
            SPI_IDLE: if (fire[0]) begin
                state_d   = SPI_LOW;
                sh_d      = bus.wr ? bus.d_reg : 8'hFF;
                mosi_d    = bus.wr ? bus.d_reg[7] : 1'b1;
                cnt_d     = div_q;
                div_lat_d = div_q;
                bit_d     = 3'd7;
            end
            SPI_LOW: if (cnt_q == '0) begin
                sck_d   = 1'b1;
                sh_d    = {sh_q[6:0], sd_miso_i};
                cnt_d   = div_lat_q;
                state_d = SPI_HIGH;
            end else cnt_d = cnt_q - 1'b1;
            SPI_HIGH: if (cnt_q == '0) begin
                sck_d   = 1'b0;
                bit_d   = bit_q - 1'b1;
                mosi_d  = (bit_q == 3'd0) ? 1'b1 : sh_q[7];
                cnt_d   = div_lat_q;
                state_d = (bit_q == 3'd0) ? SPI_DONE : SPI_LOW;
            end else cnt_d = cnt_q - 1'b1;
            SPI_DONE: begin
                rx_d    = sh_q;
                mosi_d  = 1'b1;
                state_d = SPI_IDLE;
            end
        endcase
    end
    // state and datapath registers; reset puts the SPI lines at their idle levels at once
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SPI_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= 8'hFF;
            rx_q      <= 8'hFF;
            mosi_q    <= 1'b1;
            sck_q     <= 1'b0;
            cs_q      <= '1;
            div_q     <= DIV_W'(DIV_RESET);
            div_lat_q <= DIV_W'(DIV_RESET);
            d_out_q   <= '0;
            d_act_q   <= 1'b0;
            hit_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            mosi_q    <= mosi_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            d_out_q   <= d_out_d;
            d_act_q   <= d_act_d;
            hit_q     <= hit;
        end
    end
    assign d_out_o        = d_out_q;
    assign d_out_active_o = d_act_q;
    assign sd_mosi_o      = mosi_q;
    assign sd_sck_o       = sck_q;
    assign sd_cs_n_o      = cs_q;
    assign busy_o         = state_q != SPI_IDLE;
    assign spi_wait_o     = busy_o;
endmodule
